sram_req_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one LSRAM/uSRAM control interface (the req/write/size/addr/wdata → ack/rdata port of the AHB SRAM controller) between two requesters. Typical requesters are the AHB slave front end and a fabric DMA engine. The block sits between both requesters and the SRAM controller. It serialises accesses, holds the command stable until the controller acknowledges, and returns read data to the granted requester.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arb_rr2.sv | 36 +++
 rtl/sram_req_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM encoding and AHB transfer-size constants for the
// SRAM request arbiter.
package sram_arb_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_RESP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ARB_IDLE,
    ST_ISSUE = ARB_ISSUE,
    ST_WAIT  = ARB_WAIT,
    ST_RESP  = ARB_RESP
  } arb_state_e;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

endpackage

// File: rtl/sram_arb_rr2.sv
// sram_arb_rr2: two-way round-robin grant picker. The pointer remembers the
// requester served last and only moves when the top enables an update.
module sram_arb_rr2 (
  input  logic       HCLK,
  input  logic       HRESETN,
  input  logic [1:0] req,
  input  logic       upd_en,
  input  logic       upd_idx,
  output logic       winner
);

  logic ptr_r;

  // Pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      ptr_r <= 1'b1;
    end else if (upd_en) begin
      ptr_r <= upd_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Sole requester wins; on a tie the requester not served last wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~ptr_r;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM controller port between two requesters.
// Defining SRAM_ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts with rN_err.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AHB_DWIDTH     = 32,
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic [2:0]            r0_size,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [AHB_DWIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [AHB_DWIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic [2:0]            r1_size,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [AHB_DWIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [AHB_DWIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  output logic                  m_req,
  output logic                  m_write,
  output logic [2:0]            m_size,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [AHB_DWIDTH-1:0] m_wdata,
  input  logic                  m_ack,
  input  logic [AHB_DWIDTH-1:0] m_rdata,
  input  logic                  m_busy
);

  arb_state_e            state_r;
  arb_state_e            state_nx_s;
  logic                  grant_r;
  logic                  pick_s;
  logic                  any_req_s;
  logic                  take_s;
  logic                  done_s;
  logic                  abort_s;
  logic                  finish_s;
  logic                  upd_en_s;
  logic                  tmo_hit_s;

  logic                  sel_write_s;
  logic [2:0]            sel_size_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [AHB_DWIDTH-1:0] sel_wdata_s;

  logic                  m_req_r;
  logic                  m_write_r;
  logic [2:0]            m_size_r;
  logic [ADDR_WIDTH-1:0] m_addr_r;
  logic [AHB_DWIDTH-1:0] m_wdata_r;
  logic                  r0_ack_r;
  logic                  r1_ack_r;
  logic [AHB_DWIDTH-1:0] r0_rdata_r;
  logic [AHB_DWIDTH-1:0] r1_rdata_r;

  assign any_req_s = r0_req | r1_req;
  assign finish_s  = done_s | abort_s;
  assign upd_en_s  = (state_r == ST_RESP);

  sram_arb_rr2 u_rr2 (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .req     ({r1_req, r0_req}),
    .upd_en  (upd_en_s),
    .upd_idx (grant_r),
    .winner  (pick_s)
  );

  // Command of the current arbitration winner.
  always_comb begin
    if (pick_s) begin
      sel_write_s = r1_write;
      sel_size_s  = r1_size;
      sel_addr_s  = r1_addr;
      sel_wdata_s = r1_wdata;
    end else begin
      sel_write_s = r0_write;
      sel_size_s  = r0_size;
      sel_addr_s  = r0_addr;
      sel_wdata_s = r0_wdata;
    end
  end

  // Next-state logic; m_ack only counts in WAIT, BUSY only gates grants in IDLE.
  always_comb begin
    state_nx_s = state_r;
    take_s     = 1'b0;
    done_s     = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!m_busy && any_req_s) begin
          take_s     = 1'b1;
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (m_ack) begin
          done_s     = 1'b1;
          state_nx_s = ST_RESP;
        end else if (tmo_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, grant and the command held stable towards the controller.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r   <= ST_IDLE;
      grant_r   <= 1'b0;
      m_req_r   <= 1'b0;
      m_write_r <= 1'b0;
      m_size_r  <= 3'b000;
      m_addr_r  <= {ADDR_WIDTH{1'b0}};
      m_wdata_r <= {AHB_DWIDTH{1'b0}};
    end else begin
      state_r <= state_nx_s;
      m_req_r <= take_s;
      if (take_s) begin
        grant_r   <= pick_s;
        m_write_r <= sel_write_s;
        m_size_r  <= sel_size_s;
        m_addr_r  <= sel_addr_s;
        m_wdata_r <= sel_wdata_s;
      end
    end
  end

  // Completion pulses; read data is only captured for reads that got m_ack.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r0_ack_r   <= 1'b0;
      r1_ack_r   <= 1'b0;
      r0_rdata_r <= {AHB_DWIDTH{1'b0}};
      r1_rdata_r <= {AHB_DWIDTH{1'b0}};
    end else begin
      r0_ack_r <= finish_s & ~grant_r;
      r1_ack_r <= finish_s & grant_r;
      if (done_s && !m_write_r) begin
        if (grant_r) begin
          r1_rdata_r <= m_rdata;
        end else begin
          r0_rdata_r <= m_rdata;
        end
      end
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             r0_err_r;
  logic             r1_err_r;

  // Hitting TMO_LAST in WAIT means this is the TIMEOUT_CYCLES-th WAIT cycle.
  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

  // Watchdog counter: zero on entry to WAIT, counts every WAIT cycle.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Error flags pulse together with the abort ack.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r0_err_r <= 1'b0;
      r1_err_r <= 1'b0;
    end else begin
      r0_err_r <= abort_s & ~grant_r;
      r1_err_r <= abort_s & grant_r;
    end
  end

  assign r0_err = r0_err_r;
  assign r1_err = r1_err_r;
`else
  assign tmo_hit_s = 1'b0;
  assign r0_err    = 1'b0;
  assign r1_err    = 1'b0;
`endif

  assign m_req    = m_req_r;
  assign m_write  = m_write_r;
  assign m_size   = m_size_r;
  assign m_addr   = m_addr_r;
  assign m_wdata  = m_wdata_r;
  assign r0_ack   = r0_ack_r;
  assign r1_ack   = r1_ack_r;
  assign r0_rdata = r0_rdata_r;
  assign r1_rdata = r1_rdata_r;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed cycle-accurate checks of the two-port SRAM arbiter;
// the SRAM controller side (m_ack/m_rdata) is driven by hand at known cycles.
module tb_sram_req_arbiter;
  import sram_arb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        r0_req, r0_write, r0_ack, r0_err;
  logic [2:0]  r0_size;
  logic [19:0] r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_req, r1_write, r1_ack, r1_err;
  logic [2:0]  r1_size;
  logic [19:0] r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic        m_req, m_write, m_ack, m_busy;
  logic [2:0]  m_size;
  logic [19:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_r0_rdata;
  logic [31:0] exp_r1_rdata;
  logic [31:0] fair_data;

  always #5 HCLK = ~HCLK;

  sram_req_arbiter #(
    .AHB_DWIDTH     (32),
    .ADDR_WIDTH     (20),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .HCLK     (HCLK),
    .HRESETN  (HRESETN),
    .r0_req   (r0_req),
    .r0_write (r0_write),
    .r0_size  (r0_size),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_ack   (r0_ack),
    .r0_rdata (r0_rdata),
    .r0_err   (r0_err),
    .r1_req   (r1_req),
    .r1_write (r1_write),
    .r1_size  (r1_size),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_ack   (r1_ack),
    .r1_rdata (r1_rdata),
    .r1_err   (r1_err),
    .m_req    (m_req),
    .m_write  (m_write),
    .m_size   (m_size),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .m_busy   (m_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Wait dly cycles, then pulse m_ack with read data for one cycle.
  task automatic serve(input int dly, input logic [31:0] d);
    repeat (dly) step();
    m_ack   = 1'b1;
    m_rdata = d;
    step();
    m_ack   = 1'b0;
  endtask

  initial begin
    HRESETN = 1'b0;
    r0_req = 1'b0; r0_write = 1'b0; r0_size = SZ_WORD; r0_addr = 20'h0; r0_wdata = 32'h0;
    r1_req = 1'b0; r1_write = 1'b0; r1_size = SZ_WORD; r1_addr = 20'h0; r1_wdata = 32'h0;
    m_ack = 1'b0; m_rdata = 32'h0; m_busy = 1'b0;
    exp_r0_rdata = 32'h0;
    exp_r1_rdata = 32'h0;
    repeat (2) step();

    check_eq("rst_m_req", m_req, 64'd0);
    check_eq("rst_acks_errs", {r0_ack, r1_ack, r0_err, r1_err}, 64'd0);
    check_eq("rst_cmd", {m_write, m_size, m_addr, m_wdata}, 64'd0);
    check_eq("rst_rdata", {r0_rdata, r1_rdata}, 64'd0);
    HRESETN = 1'b1;
    step();

    // Single read from r0: m_req in cycle 1, r0_ack in cycle 4.
    r0_req = 1'b1; r0_write = 1'b0; r0_size = SZ_WORD; r0_addr = 20'h00010;
    step();
    check_eq("t1_mreq_c1", m_req, 64'd1);
    check_eq("t1_cmd", {m_write, m_size, m_addr}, {1'b0, SZ_WORD, 20'h00010});
    step();
    check_eq("t1_mreq_c2", m_req, 64'd0);
    serve(1, 32'hDEADBEEF);
    check_eq("t1_r0_ack", r0_ack, 64'd1);
    check_eq("t1_r1_ack", r1_ack, 64'd0);
    check_eq("t1_r0_err", r0_err, 64'd0);
    check_eq("t1_rdata", r0_rdata, 64'h0000_0000_DEAD_BEEF);
    exp_r0_rdata = 32'hDEADBEEF;
    r0_req = 1'b0;
    step();
    check_eq("t1_ack_one_cycle", r0_ack, 64'd0);
    check_eq("t1_rdata_hold", r0_rdata, {32'h0, exp_r0_rdata});

    // Reset in WAIT aborts without ack and clears everything.
    r1_req = 1'b1; r1_write = 1'b0; r1_addr = 20'h00040;
    step();
    check_eq("mid_mreq", m_req, 64'd1);
    step();
    HRESETN = 1'b0;
    #1;
    check_eq("mid_rst_out", {m_req, r0_ack, r1_ack, m_addr}, 64'd0);
    check_eq("mid_rst_rdata", r0_rdata, 64'd0);
    exp_r0_rdata = 32'h0;
    r1_req = 1'b0;
    step();
    HRESETN = 1'b1;
    m_ack   = 1'b1;
    m_rdata = 32'h55555555;
    step();
    m_ack = 1'b0;
    check_eq("mid_no_ack", {r0_ack, r1_ack, m_req}, 64'd0);
    step();

    // Simultaneous r0 write and r1 read after reset: r0 first, r1 m_req in cycle 6.
    r0_req = 1'b1; r0_write = 1'b1; r0_size = SZ_WORD; r0_addr = 20'h00020; r0_wdata = 32'h11112222;
    r1_req = 1'b1; r1_write = 1'b0; r1_size = SZ_WORD; r1_addr = 20'h00030;
    step();
    check_eq("t2_mreq_r0", m_req, 64'd1);
    check_eq("t2_cmd_r0", {m_write, m_addr, m_wdata}, {1'b1, 20'h00020, 32'h11112222});
    serve(2, 32'hBAD0BAD0);
    check_eq("t2_acks_c4", {r1_ack, r0_ack}, 64'd1);
    check_eq("t2_write_no_rdata", r0_rdata, {32'h0, exp_r0_rdata});
    r0_req = 1'b0;
    step();
    check_eq("t2_mreq_c5", m_req, 64'd0);
    step();
    check_eq("t2_mreq_c6", m_req, 64'd1);
    check_eq("t2_cmd_r1", {m_write, m_addr}, {1'b0, 20'h00030});
    serve(2, 32'h12345678);
    check_eq("t2_acks_c9", {r1_ack, r0_ack}, 64'd2);
    check_eq("t2_r1_rdata", r1_rdata, 64'h0000_0000_1234_5678);
    exp_r1_rdata = 32'h12345678;

    // Both held continuously: grants alternate 0,1,0,1...
    r0_req = 1'b1; r0_write = 1'b0; r0_addr = 20'h00100;
    r1_addr = 20'h00200;
    for (int i = 0; i < 10; i++) begin
      fair_data = 32'hA5000000 | 32'(i);
      step();
      step();
      check_eq("fair_mreq", m_req, 64'd1);
      check_eq("fair_addr", m_addr, (i % 2 == 1) ? 64'h200 : 64'h100);
      serve(2, fair_data);
      check_eq("fair_ack", {r1_ack, r0_ack}, (i % 2 == 1) ? 64'd2 : 64'd1);
      if (i % 2 == 1) exp_r1_rdata = fair_data;
      else            exp_r0_rdata = fair_data;
      check_eq("fair_rdata", {r1_rdata, r0_rdata}, {exp_r1_rdata, exp_r0_rdata});
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    step();

    // BUSY for 7 cycles holds off the grant; m_req one cycle after it falls.
    m_busy = 1'b1;
    r1_req = 1'b1; r1_write = 1'b0; r1_addr = 20'h00300;
    for (int k = 0; k < 7; k++) begin
      step();
      check_eq("busy_no_mreq", m_req, 64'd0);
    end
    m_busy = 1'b0;
    step();
    check_eq("busy_mreq_after", m_req, 64'd1);
    check_eq("busy_addr", m_addr, 64'h300);
    m_busy = 1'b1;
    serve(2, 32'hCAFEF00D);
    check_eq("busy_in_wait_ack", r1_ack, 64'd1);
    check_eq("busy_rdata", r1_rdata, 64'h0000_0000_CAFE_F00D);
    exp_r1_rdata = 32'hCAFEF00D;
    m_busy = 1'b0;
    r1_req = 1'b0;
    step();

    // Stray m_ack in IDLE is ignored.
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    check_eq("idle_ack_ignored", {r0_ack, r1_ack, m_req}, 64'd0);

    // Halfword write with m_ack delayed 6 cycles: command stays constant.
    r0_req = 1'b1; r0_write = 1'b1; r0_size = SZ_HALF; r0_addr = 20'h00006; r0_wdata = 32'h0000ABCD;
    step();
    check_eq("stab_c1", {m_req, m_write, m_size, m_addr, m_wdata},
             {1'b1, 1'b1, SZ_HALF, 20'h00006, 32'h0000ABCD});
    r0_req = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      step();
      check_eq("stab_wait", {m_req, m_write, m_size, m_addr, m_wdata},
               {1'b0, 1'b1, SZ_HALF, 20'h00006, 32'h0000ABCD});
      check_eq("stab_no_ack", r0_ack, 64'd0);
    end
    step();
    m_ack = 1'b1;
    check_eq("stab_c7", {m_req, m_write, m_size, m_addr, m_wdata},
             {1'b0, 1'b1, SZ_HALF, 20'h00006, 32'h0000ABCD});
    step();
    m_ack = 1'b0;
    check_eq("stab_ack", {r1_ack, r0_ack}, 64'd1);
    check_eq("stab_rdata_kept", r0_rdata, {32'h0, exp_r0_rdata});
    step();

`ifdef SRAM_ARB_TIMEOUT_EN
    // No m_ack: abort after 16 WAIT cycles, late m_ack dropped, next request normal.
    r0_req = 1'b1; r0_write = 1'b0; r0_size = SZ_WORD; r0_addr = 20'h00080;
    step();
    check_eq("tmo_mreq", m_req, 64'd1);
    repeat (16) step();
    check_eq("tmo_not_early", {r0_ack, r0_err}, 64'd0);
    step();
    check_eq("tmo_ack_err", {r0_ack, r0_err}, 64'd3);
    check_eq("tmo_rdata_kept", r0_rdata, {32'h0, exp_r0_rdata});
    r0_req = 1'b0;
    step();
    m_ack   = 1'b1;
    m_rdata = 32'h77777777;
    step();
    m_ack = 1'b0;
    check_eq("tmo_late_ack", {r0_ack, r0_err, r1_ack, r1_err}, 64'd0);
    r1_req = 1'b1; r1_write = 1'b0; r1_addr = 20'h00090;
    step();
    check_eq("tmo_next_mreq", m_req, 64'd1);
    serve(2, 32'h600DF00D);
    check_eq("tmo_next_ack", {r1_ack, r1_err}, 64'd2);
    check_eq("tmo_next_rdata", r1_rdata, 64'h0000_0000_600D_F00D);
    r1_req = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
